// File: rtl/iob_wb2iob_pkg.sv
// Shared definitions for the Wishbone-to-IOb bridge.
// Holds the FSM state encoding and the timeout counter sizing rule.
package iob_wb2iob_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK   = 3'd2,
        ERR   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/iob_counter.sv
// Up-counter with synchronous clear and enable.
// Used to time how long the IOb slave withholds ready.
module iob_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/iob_wb2iob.sv
// Wishbone slave to IOb master bridge with address decode,
// ready timeout and cycle-abort handling.
module iob_wb2iob
    import iob_wb2iob_pkg::*;
#(
    parameter int                   WB_ADDR_W = 32,
    parameter int                   ADDR_W    = 16,
    parameter int                   DATA_W    = 32,
    parameter logic [WB_ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                   TIMEOUT   = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WB_ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0]    wb_dat_i,
    input  logic [DATA_W/8-1:0]  wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic [DATA_W-1:0]    wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 valid,
    output logic [ADDR_W-1:0]    address,
    output logic [DATA_W-1:0]    wdata,
    output logic [DATA_W/8-1:0]  wstrb,
    input  logic [DATA_W-1:0]    rdata,
    input  logic                 ready
);

    localparam int SW = DATA_W / 8;
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TERM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state;
    state_t            state_nxt;
    logic              err_q;
    logic              err_nxt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SW-1:0]     wstrb_q;
    logic [CW-1:0]     cnt;
    logic              hit;
    logic              tmo;
    logic              start;
    logic              cap;
    logic              cnt_en;
    logic              unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];

    if (WB_ADDR_W > ADDR_W) begin : g_dec
        assign hit = (wb_adr_i[WB_ADDR_W-1:ADDR_W]
                      == BASE_ADDR[WB_ADDR_W-ADDR_W-1:0]);
    end else begin : g_nodec
        assign hit = 1'b1;
    end

    assign tmo = (TIMEOUT != 0) && (cnt == TERM);

    iob_counter #(
        .W(CW)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(start),
        .en (cnt_en),
        .cnt(cnt)
    );

    // Ready has priority over abort and timeout: a completed
    // IOb access must never be followed by a drain wait.
    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        start     = 1'b0;
        cap       = 1'b0;
        cnt_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (hit) begin
                        start     = 1'b1;
                        err_nxt   = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
            REQ: begin
                if (ready) begin
                    state_nxt = wb_cyc_i ? ACK : IDLE;
                    cap       = wb_cyc_i && !we_q;
                end else if (!wb_cyc_i) begin
                    err_nxt   = 1'b0;
                    state_nxt = DRAIN;
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ACK:   state_nxt = IDLE;
            ERR:   state_nxt = IDLE;
            DRAIN: begin
                if (ready) begin
                    state_nxt = err_q ? ERR : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
        end else if (start) begin
            addr_q  <= {wb_adr_i[ADDR_W-1:2], 2'b00};
            wdata_q <= wb_dat_i;
            wstrb_q <= wb_sel_i & {SW{wb_we_i}};
            we_q    <= wb_we_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_dat_o <= '0;
        end else if (cap) begin
            wb_dat_o <= rdata;
        end
    end

    assign valid    = (state == REQ) || (state == DRAIN);
    assign wb_ack_o = (state == ACK);
    assign wb_err_o = (state == ERR);
    assign address  = addr_q;
    assign wdata    = wdata_q;
    assign wstrb    = wstrb_q;

endmodule

// File: doc/iob_wb2iob.md
IOB_WB2IOB -- requirements
Module: iob_wb2iob

Interface
REQ-001 Parameters: WB_ADDR_W, default 32, Wishbone byte-address width; ADDR_W, default 16, IOb byte-address width (ADDR_W <= WB_ADDR_W); DATA_W, default 32, data width for both buses; BASE_ADDR, default 0, required value of wb_adr_i[WB_ADDR_W-1:ADDR_W]; TIMEOUT, default 256, cycles to wait for IOb ready (0 = no timeout).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- wb_adr_i  in  WB_ADDR_W  Wishbone byte address.
- wb_dat_i  in  DATA_W  Wishbone write data.
- wb_sel_i  in  DATA_W/8  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  DATA_W  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error.
- valid  out  1  IOb request.
- address  out  ADDR_W  IOb address.
- wdata  out  DATA_W  IOb write data.
- wstrb  out  DATA_W/8  IOb write strobes (0 = read).
- rdata  in  DATA_W  IOb read data, valid while ready=1.
- ready  in  1  IOb completion.

Function
REQ-004 FSM states: IDLE, REQ, ACK, ERR, DRAIN; encoding is a shared package constant.
REQ-005 IDLE: when wb_cyc_i & wb_stb_i = 1 and the upper address matches BASE_ADDR, latch wb_adr_i[ADDR_W-1:2] (low 2 bits forced 0), wb_dat_i, wb_sel_i and wb_we_i, then go to REQ.
REQ-006 IDLE: on cyc&stb with an upper-address mismatch, go to ERR; no IOb request is issued.
REQ-007 REQ: valid=1; address, wdata, and wstrb (wb_sel latched & {DATA_W/8{we}}) are driven from the latches and held stable until ready.
REQ-008 REQ with ready=1: capture rdata into the wb_dat_o register (reads only; writes leave it unchanged) and go to ACK; valid is 0 from the next cycle.
REQ-009 ACK: wb_ack_o=1 for exactly one cycle, then go to IDLE; minimum transfer latency is stb-to-ack = 2 cycles with ready in the first REQ cycle.
REQ-010 Timeout counter: cleared on entering REQ, incremented every REQ cycle without ready; when it reaches TIMEOUT-1 without ready, go to DRAIN with the error flag set.
REQ-011 Ready in the same cycle as the timeout terminal count: ready wins, normal ACK.
REQ-012 DRAIN: valid stays 1 until ready (IOb cannot abort); on ready go to ERR if the error flag is set, else to IDLE with no ack. rdata is discarded.
REQ-013 ERR: wb_err_o=1 for exactly one cycle, then go to IDLE; wb_ack_o and wb_err_o are never both 1.
REQ-014 Abort: if wb_cyc_i drops while in REQ, go to DRAIN with the error flag clear; no ack or err is given for that transfer.
REQ-015 Back-to-back transfers: stb held after ack/err in IDLE is a new transfer; no idle cycle is required beyond the ACK/ERR cycle.
REQ-016 wb_dat_o holds its last captured value outside ACK.

Reset
REQ-017 On rst=1 at a clk edge: state=IDLE, valid=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, address/wdata/wstrb=0, counter=0, error flag=0.
REQ-018 Reset mid-transfer drops valid in the next cycle without waiting for ready; the IOb slave must be reset by the same rst.

Structure
REQ-019 The shared package holds the FSM state encoding and the TIMEOUT counter width ($clog2(TIMEOUT+1), minimum 1).
REQ-020 Registers use the codebase iob_reg (reset value parameterized) or equivalent synchronous flops; a single sub-module, iob_counter, implements the timeout counter with clear and enable.

Verification
REQ-021 Write: adr=0x0000_0010, dat=0xDEADBEEF, sel=0xF, we=1, ready after 3 cycles -> address=0x0010, wstrb=0xF, wdata=0xDEADBEEF, valid for 3 cycles, one-cycle ack.
REQ-022 Read: adr=0x0000_0024, sel=0x3, ready with rdata=0x12345678 in the first REQ cycle -> wstrb=0, address=0x0024, wb_dat_o=0x12345678 with ack 2 cycles after stb.
REQ-023 Decode error: BASE_ADDR=0, adr=0x0001_0000 -> valid never 1, wb_err_o=1 for one cycle.
REQ-024 Timeout: TIMEOUT=8, ready held 0 for 20 cycles then 1 -> valid held 21 cycles, err one cycle after ready, no ack.
REQ-025 Abort and reset: cyc dropped in cycle 2 of REQ, ready in cycle 5 -> no ack/err, return to IDLE. Separately, rst asserted during REQ -> all outputs 0 next cycle.
